// File: rtl/led_mat_pkg.sv
// Timing defaults and transmitter state encoding for the DPI source slice.
// Defaults describe a 3*120x90 panel frame.
package led_mat_pkg;

    localparam int unsigned H_ACTIVE_DEF = 360;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 32;
    localparam int unsigned H_BP_DEF     = 40;
    localparam int unsigned V_ACTIVE_DEF = 90;
    localparam int unsigned V_FP_DEF     = 3;
    localparam int unsigned V_SYNC_DEF   = 4;
    localparam int unsigned V_BP_DEF     = 10;
    localparam int unsigned PCLK_DIV_DEF = 2;

    localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_t;

endpackage

// File: rtl/dpi_timing_cnt.sv
// Slot timing counters: div within a pixel slot, h within a line, v within a frame.
// All counters sit at zero while run is low.
module dpi_timing_cnt #(
    parameter int unsigned PCLK_DIV = 2,
    parameter int unsigned H_TOTAL  = 448,
    parameter int unsigned V_TOTAL  = 107,
    parameter int unsigned DW       = $clog2(PCLK_DIV),
    parameter int unsigned HW       = $clog2(H_TOTAL),
    parameter int unsigned VW       = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [DW-1:0] div,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          frame_end
);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          slot_end;
    logic          line_end;

    always_comb begin
        slot_end  = run && (32'(div_q) == PCLK_DIV - 1);
        line_end  = slot_end && (32'(h_q) == H_TOTAL - 1);
        frame_end = line_end && (32'(v_q) == V_TOTAL - 1);
        div_d     = div_q + DW'(1);
        h_d       = h_q;
        v_d       = v_q;
        if (!run) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (slot_end) begin
            div_d = '0;
            if (line_end) begin
                h_d = '0;
                v_d = frame_end ? '0 : v_q + VW'(1);
            end else begin
                h_d = h_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    assign div = div_q;
    assign h   = h_q;
    assign v   = v_q;

endmodule

// File: rtl/dpi_tx_gen.sv
// DPI parallel-RGB transmitter: run/drain control, pixel fetch strobe and
// registered sync/DE/RGB/pixel-clock outputs.
module dpi_tx_gen
    import led_mat_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PCLK_DIV = PCLK_DIV_DEF
) (
    input  logic        MCLK_IN,
    input  logic        RESET,
    input  logic        ENABLE,
    output logic        PIX_REQ,
    output logic [8:0]  PIX_X,
    output logic [6:0]  PIX_Y,
    input  logic [23:0] PIX_RGB,
    output logic        DPI_PCLK,
    output logic        DPI_H_SYNC,
    output logic        DPI_V_SYNC,
    output logic        DPI_DE,
    output logic [7:0]  DPI_R,
    output logic [7:0]  DPI_G,
    output logic [7:0]  DPI_B,
    output logic        FRAME_START,
    output logic        BUSY
);

    localparam int unsigned H_TOT     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW        = $clog2(PCLK_DIV);
    localparam int unsigned HW        = $clog2(H_TOT);
    localparam int unsigned VW        = $clog2(V_TOT);
    // PCLK falls with the output update and rises half a slot later.
    localparam int unsigned PCLK_RISE = (1 + PCLK_DIV / 2) % PCLK_DIV;

    tx_state_t     state_q, state_d;
    logic          running;
    logic          active;
    logic          in_hsync;
    logic          in_vsync;
    logic          at_origin;
    logic          frame_end;
    logic [DW-1:0] cnt_div;
    logic [HW-1:0] cnt_h;
    logic [VW-1:0] cnt_v;

    logic          pclk_q, pclk_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;
    logic [23:0]   rgb_q, rgb_d;

    dpi_timing_cnt #(
        .PCLK_DIV (PCLK_DIV),
        .H_TOTAL  (H_TOT),
        .V_TOTAL  (V_TOT),
        .DW       (DW),
        .HW       (HW),
        .VW       (VW)
    ) u_cnt (
        .clk       (MCLK_IN),
        .rst       (RESET),
        .run       (running),
        .div       (cnt_div),
        .h         (cnt_h),
        .v         (cnt_v),
        .frame_end (frame_end)
    );

    always_ff @(posedge MCLK_IN) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A frame is never cut short: dropping ENABLE only matters at frame end.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (ENABLE) state_d = ST_RUN;
            ST_RUN:   if (!ENABLE) state_d = frame_end ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (ENABLE) begin
                    state_d = ST_RUN;
                end else if (frame_end) begin
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running   = (state_q != ST_IDLE);
        BUSY      = running;
        active    = (32'(cnt_h) < H_ACTIVE) && (32'(cnt_v) < V_ACTIVE);
        in_hsync  = (32'(cnt_h) >= H_ACTIVE + H_FP) && (32'(cnt_h) < H_ACTIVE + H_FP + H_SYNC);
        in_vsync  = (32'(cnt_v) >= V_ACTIVE + V_FP) && (32'(cnt_v) < V_ACTIVE + V_FP + V_SYNC);
        at_origin = (cnt_h == '0) && (cnt_v == '0);
        PIX_REQ   = running && (cnt_div == '0) && active;
        PIX_X     = 9'(cnt_h);
        PIX_Y     = 7'(cnt_v);
    end

    always_comb begin
        pclk_d = pclk_q;
        de_d   = de_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        rgb_d  = rgb_q;
        fs_d   = 1'b0;
        if (state_d == ST_IDLE) begin
            pclk_d = 1'b0;
            de_d   = 1'b0;
            hs_d   = ~HS_POL;
            vs_d   = ~VS_POL;
            rgb_d  = '0;
        end else if (running) begin
            if (32'(cnt_div) == 1) begin
                de_d   = active;
                rgb_d  = active ? PIX_RGB : '0;
                hs_d   = in_hsync ? HS_POL : ~HS_POL;
                vs_d   = in_vsync ? VS_POL : ~VS_POL;
                fs_d   = at_origin;
                pclk_d = 1'b0;
            end else if (32'(cnt_div) == PCLK_RISE) begin
                pclk_d = 1'b1;
            end
        end
    end

    always_ff @(posedge MCLK_IN) begin
        if (RESET) begin
            pclk_q <= 1'b0;
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            rgb_q  <= '0;
            fs_q   <= 1'b0;
        end else begin
            pclk_q <= pclk_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
            fs_q   <= fs_d;
        end
    end

    assign DPI_PCLK    = pclk_q;
    assign DPI_DE      = de_q;
    assign DPI_H_SYNC  = hs_q;
    assign DPI_V_SYNC  = vs_q;
    assign DPI_R       = rgb_q[23:16];
    assign DPI_G       = rgb_q[15:8];
    assign DPI_B       = rgb_q[7:0];
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_dpi_tx_gen.sv
// Bench for dpi_tx_gen on a reduced frame geometry; every cycle is compared against
// an arithmetic model of the slot timeline measured from the first RUN edge.
module tb_dpi_tx_gen;

    localparam int HA = 12, HFP = 2, HSW = 3, HBP = 4;
    localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 2;
    localparam int DIV = 4;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT * DIV;

    typedef struct packed {
        logic        req;
        logic [8:0]  x;
        logic [6:0]  y;
        logic        pclk;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic        fs;
        logic        busy;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [23:0] pix_rgb;
    logic        req;
    logic [8:0]  x;
    logic [6:0]  y;
    logic        pclk, hs, vs, de, fs, busy;
    logic [7:0]  r, g, b;

    int n_checks = 0;
    int n_fail   = 0;

    dpi_tx_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .HS_POL   (HPOL), .VS_POL (VPOL), .PCLK_DIV (DIV)
    ) dut (
        .MCLK_IN     (clk),
        .RESET       (rst),
        .ENABLE      (en),
        .PIX_REQ     (req),
        .PIX_X       (x),
        .PIX_Y       (y),
        .PIX_RGB     (pix_rgb),
        .DPI_PCLK    (pclk),
        .DPI_H_SYNC  (hs),
        .DPI_V_SYNC  (vs),
        .DPI_DE      (de),
        .DPI_R       (r),
        .DPI_G       (g),
        .DPI_B       (b),
        .FRAME_START (fs),
        .BUSY        (busy)
    );

    always #5 clk = ~clk;

    // One-cycle-latency pixel source; garbage outside the fetch response cycle.
    always @(posedge clk) pix_rgb <= req ? {8'(x), 8'(y), 8'hA5} : 24'($urandom);

    function automatic logic [23:0] pix(input int hh, input int vv);
        return {8'(hh), 8'(vv), 8'hA5};
    endfunction

    function automatic obs_t idle_obs();
        obs_t e;
        e = '0;
        e.hs = !HPOL;
        e.vs = !VPOL;
        return e;
    endfunction

    // t = MCLK cycles since the RUN edge; nfr = frames that run before idling.
    function automatic obs_t model(input int t, input int nfr);
        obs_t e;
        int s, sp, q, hh, vv;
        bit act;
        e = idle_obs();
        if (t < 0 || t >= nfr * FRAME) return e;
        e.busy = 1'b1;
        s  = t / DIV;
        hh = s % HT;
        vv = (s / HT) % VT;
        e.req = (t % DIV == 0) && hh < HA && vv < VA;
        if (e.req) begin
            e.x = 9'(hh);
            e.y = 7'(vv);
        end
        if (t >= 2) begin
            sp  = (t - 2) / DIV;
            q   = (t - 2) % DIV;
            hh  = sp % HT;
            vv  = (sp / HT) % VT;
            act = hh < HA && vv < VA;
            e.de   = act;
            e.rgb  = act ? pix(hh, vv) : 24'h0;
            e.hs   = (hh >= HA + HFP && hh < HA + HFP + HSW) ? HPOL : !HPOL;
            e.vs   = (vv >= VA + VFP && vv < VA + VFP + VSW) ? VPOL : !VPOL;
            e.fs   = (q == 0) && (sp % (HT * VT) == 0);
            e.pclk = (q >= DIV / 2);
        end
        return e;
    endfunction

    function automatic obs_t sample(input bit keep_xy);
        obs_t o;
        o.req  = req;
        o.x    = keep_xy ? x : 9'h0;
        o.y    = keep_xy ? y : 7'h0;
        o.pclk = pclk;
        o.hs   = hs;
        o.vs   = vs;
        o.de   = de;
        o.rgb  = {r, g, b};
        o.fs   = fs;
        o.busy = busy;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("req=%b x=%0d y=%0d pclk=%b hs=%b vs=%b de=%b rgb=%h fs=%b busy=%b",
                         o.req, o.x, o.y, o.pclk, o.hs, o.vs, o.de, o.rgb, o.fs, o.busy);
    endfunction

    task automatic test_reset();
        obs_t got, exp;
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp = model(-1, 0);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL reset i=%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
    endtask

    task automatic test_pixel_data();
        obs_t got, exp;
        int   t_drop, de_px, de_rows;
        logic prev_pclk;
        t_drop    = int'($urandom_range(FRAME - 1, 0));
        de_px     = 0;
        de_rows   = 0;
        prev_pclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < FRAME + 6; t++) begin
            @(negedge clk);
            exp = model(t, 1);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pixel t=%0d got %s want %s", t, fmt(got), fmt(exp));
            end
            if (pclk && !prev_pclk && de) begin
                de_px++;
                if (r == 8'h00) de_rows++;
            end
            prev_pclk = pclk;
            if (t == t_drop) en = 1'b0;
        end
        n_checks++;
        if (de_px != HA * VA) begin
            n_fail++;
            $display("FAIL de_pixel_count got %0d want %0d", de_px, HA * VA);
        end
        n_checks++;
        if (de_rows != VA) begin
            n_fail++;
            $display("FAIL de_line_count got %0d want %0d", de_rows, VA);
        end
    endtask

    task automatic test_free_run();
        obs_t got, exp;
        int   t_drop, hs_fall, vs_fall, fs_last, fs_cnt;
        logic prev_hs, prev_vs;
        t_drop  = int'($urandom_range(3 * FRAME - 1, 2 * FRAME));
        hs_fall = -1;
        vs_fall = -1;
        fs_last = -1;
        fs_cnt  = 0;
        prev_hs = 1'b1;
        prev_vs = 1'b1;
        @(negedge clk);
        en = 1'b1;
        for (int t = 0; t < 3 * FRAME + 6; t++) begin
            @(negedge clk);
            exp = model(t, 3);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL freerun t=%0d got %s want %s", t, fmt(got), fmt(exp));
            end
            if (prev_hs && !hs) begin
                if (hs_fall >= 0) begin
                    n_checks++;
                    if (t - hs_fall != HT * DIV) begin
                        n_fail++;
                        $display("FAIL line_period got %0d want %0d", t - hs_fall, HT * DIV);
                    end
                end
                hs_fall = t;
            end
            if (!prev_hs && hs) begin
                n_checks++;
                if (t - hs_fall != HSW * DIV) begin
                    n_fail++;
                    $display("FAIL hsync_width got %0d want %0d", t - hs_fall, HSW * DIV);
                end
            end
            if (prev_vs && !vs) vs_fall = t;
            if (!prev_vs && vs) begin
                n_checks++;
                if (t - vs_fall != VSW * HT * DIV) begin
                    n_fail++;
                    $display("FAIL vsync_width got %0d want %0d", t - vs_fall, VSW * HT * DIV);
                end
            end
            if (fs) begin
                fs_cnt++;
                n_checks++;
                if (!de || {r, g, b} !== pix(0, 0)) begin
                    n_fail++;
                    $display("FAIL frame_start_pixel got de=%b rgb=%h want de=1 rgb=%h",
                             de, {r, g, b}, pix(0, 0));
                end
                if (fs_last >= 0) begin
                    n_checks++;
                    if (t - fs_last != FRAME) begin
                        n_fail++;
                        $display("FAIL frame_period got %0d want %0d", t - fs_last, FRAME);
                    end
                end
                fs_last = t;
            end
            prev_hs = hs;
            prev_vs = vs;
            if (t == t_drop) en = 1'b0;
        end
        n_checks++;
        if (fs_cnt != 3) begin
            n_fail++;
            $display("FAIL frame_start_count got %0d want 3", fs_cnt);
        end
    endtask

    task automatic test_drain();
        obs_t got, exp;
        int   t_drop, busy_fall;
        logic prev_busy;
        t_drop    = (VA / 2) * HT * DIV + int'($urandom_range(HT * DIV - 1, 0));
        busy_fall = -1;
        prev_busy = 1'b0;
        @(negedge clk);
        en = 1'b1;
        for (int t = 0; t < FRAME + 8; t++) begin
            @(negedge clk);
            exp = model(t, 1);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL drain t=%0d got %s want %s", t, fmt(got), fmt(exp));
            end
            if (prev_busy && !busy && busy_fall < 0) busy_fall = t;
            prev_busy = busy;
            if (t == t_drop) en = 1'b0;
        end
        n_checks++;
        if (busy_fall != FRAME) begin
            n_fail++;
            $display("FAIL busy_fall_time got %0d want %0d", busy_fall, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got, exp;
        int   t1, t2, t3;
        t1 = int'($urandom_range(FRAME / 2, 0));
        t2 = int'($urandom_range(FRAME - 1, t1 + 1));
        t3 = int'($urandom_range(2 * FRAME - 1, FRAME));
        @(negedge clk);
        en = 1'b1;
        for (int t = 0; t < 2 * FRAME + 6; t++) begin
            @(negedge clk);
            exp = model(t, 2);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL redrain t=%0d got %s want %s", t, fmt(got), fmt(exp));
            end
            if (t == t1) en = 1'b0;
            if (t == t2) en = 1'b1;
            if (t == t3) en = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        obs_t got, exp;
        int   t_r;
        t_r = (3 * HT + 7) * DIV + int'($urandom_range(DIV - 1, 0));
        @(negedge clk);
        en = 1'b1;
        for (int t = 0; t <= t_r; t++) begin
            @(negedge clk);
            exp = model(t, 100);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pre_reset t=%0d got %s want %s", t, fmt(got), fmt(exp));
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp = model(-1, 0);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_reset i=%0d got %s want %s", i, fmt(got), fmt(exp));
            end
        end
        rst = 1'b0;
        for (int t = 0; t < 2 * HT * DIV; t++) begin
            @(negedge clk);
            if (t == 0) begin
                n_checks++;
                if (req !== 1'b1 || x !== 9'd0 || y !== 7'd0) begin
                    n_fail++;
                    $display("FAIL restart_first_req got req=%b x=%0d y=%0d want req=1 x=0 y=0",
                             req, x, y);
                end
            end
            exp = model(t, 100);
            got = sample(exp.req);
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL post_reset t=%0d got %s want %s", t, fmt(got), fmt(exp));
            end
        end
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pixel_data();
        test_free_run();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
